// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared definitions for the SDRAM command arbiter: one-hot state
// encodings, the state vector width and the FSM state type.
package sdram_arb_pkg;

    localparam int unsigned ST_W = 5;

    localparam logic [ST_W-1:0] ST_IDLE  = 5'b00001;
    localparam logic [ST_W-1:0] ST_INIT  = 5'b00010;
    localparam logic [ST_W-1:0] ST_ARBIT = 5'b00100;
    localparam logic [ST_W-1:0] ST_AREF  = 5'b01000;
    localparam logic [ST_W-1:0] ST_OP    = 5'b10000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_INIT  = ST_INIT,
        S_ARBIT = ST_ARBIT,
        S_AREF  = ST_AREF,
        S_OP    = ST_OP
    } state_t;

endpackage

// File: rtl/sdram_arb_rr_if.sv
// sdram_arb_rr_if
// Bundles the arbiter's request/handshake signals.
//   master : requester side (init block, refresh timer, user ports, sequencer)
//   slave  : arbiter side
// Signals:
//   key, flag_init_end, ref_req, port_req[NUM_PORTS], flag_ref_end,
//   flag_op_end                       -> towards the arbiter
//   ref_en, op_en, grant[NUM_PORTS], state[5], err_timeout -> from the arbiter
interface sdram_arb_rr_if
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
);
    logic                 key;
    logic                 flag_init_end;
    logic                 ref_req;
    logic [NUM_PORTS-1:0] port_req;
    logic                 flag_ref_end;
    logic                 flag_op_end;
    logic                 ref_en;
    logic                 op_en;
    logic [NUM_PORTS-1:0] grant;
    logic [ST_W-1:0]      state;
    logic                 err_timeout;

    modport master (
        output key, flag_init_end, ref_req, port_req, flag_ref_end, flag_op_end,
        input  ref_en, op_en, grant, state, err_timeout
    );

    modport slave (
        input  key, flag_init_end, ref_req, port_req, flag_ref_end, flag_op_end,
        output ref_en, op_en, grant, state, err_timeout
    );
endinterface

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick
// Combinational rotating priority encoder: returns the first set bit of
// i_pend searching upward from i_ptr (wrapping) as a one-hot vector.
// Ports:
//   i_pend  [NUM_PORTS] pending requests
//   i_ptr   [PTR_W]     search start index (tie to 0 for fixed priority)
//   o_win   [NUM_PORTS] one-hot winner (0 when nothing pending)
//   o_valid             at least one request pending
module sdram_rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PTR_W     = 2
)(
    input  logic [NUM_PORTS-1:0] i_pend,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_win,
    output logic                 o_valid
);
    logic [NUM_PORTS-1:0] w_rot;
    logic [NUM_PORTS-1:0] w_rot_oh;
    logic                 w_found;

    // Rotate right by ptr so the search always starts at bit 0, pick the
    // lowest set bit, then rotate the one-hot result back left by ptr.
    assign w_rot = (i_pend >> i_ptr) | (i_pend << (NUM_PORTS - 32'(i_ptr)));

    always_comb begin
        w_rot_oh = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_rot[i]) begin
                w_rot_oh[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign o_win   = (w_rot_oh << i_ptr) | (w_rot_oh >> (NUM_PORTS - 32'(i_ptr)));
    assign o_valid = |i_pend;

endmodule

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr
// SDRAM command arbiter between init, auto-refresh and NUM_PORTS user
// ports. After init it grants one activity at a time; refresh always wins
// an arbitration point; ports share the bus through a rotating pointer.
// A watchdog aborts a grant that never reports completion.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : rotating-priority port selection
//   undefined : fixed priority, lowest pending index wins
// Ports:
//   sclk     system clock (rising edge)
//   s_rst_n  asynchronous active-low reset
//   bus      sdram_arb_rr_if.slave (requests in; ref_en, op_en, grant,
//            state, err_timeout out -- all registered)
module sdram_arb_rr
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned TO_W      = 10
)(
    input  logic          sclk,
    input  logic          s_rst_n,
    sdram_arb_rr_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    state_t               r_state, w_nxt_state;
    logic                 r_ref_en, w_ref_en;
    logic                 r_op_en, w_op_en;
    logic                 r_err, w_err;
    logic [NUM_PORTS-1:0] r_grant, w_grant;
    logic [NUM_PORTS-1:0] r_pend, w_pend;
    logic [NUM_PORTS-1:0] w_clr;
    logic [NUM_PORTS-1:0] w_win;
    logic                 w_valid;
    logic [TO_W-1:0]      r_cnt, w_cnt;
    logic                 w_expire;
    logic [PTR_W-1:0]     w_ptr;

`ifdef ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_ptr, w_nxt_ptr;

    assign w_ptr = r_ptr;

    always_comb begin
        w_nxt_ptr = r_ptr;
        if (w_op_en) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (w_win[i]) begin
                    w_nxt_ptr = (i == NUM_PORTS - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_nxt_ptr;
        end
    end
`else
    assign w_ptr = '0;
`endif

    sdram_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .i_pend  (r_pend),
        .i_ptr   (w_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    // Counter is 0 on the first cycle in AREF/OP, so the abort edge lands
    // exactly TIMEOUT cycles after the entry edge.
    assign w_expire = (r_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_nxt_state = r_state;
        w_ref_en    = 1'b0;
        w_op_en     = 1'b0;
        w_err       = 1'b0;
        w_grant     = r_grant;
        w_clr       = '0;
        w_cnt       = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.key) w_nxt_state = S_INIT;
            end
            S_INIT: begin
                if (bus.flag_init_end) w_nxt_state = S_ARBIT;
            end
            S_ARBIT: begin
                if (bus.ref_req) begin
                    w_nxt_state = S_AREF;
                    w_ref_en    = 1'b1;
                end else if (w_valid) begin
                    w_nxt_state = S_OP;
                    w_op_en     = 1'b1;
                    w_grant     = w_win;
                    w_clr       = w_win;
                end
            end
            S_AREF: begin
                w_cnt = r_cnt + 1'b1;
                if (bus.flag_ref_end) begin
                    w_nxt_state = S_ARBIT;
                end else if (w_expire) begin
                    w_nxt_state = S_ARBIT;
                    w_err       = 1'b1;
                end
            end
            S_OP: begin
                w_cnt = r_cnt + 1'b1;
                if (bus.flag_op_end) begin
                    w_nxt_state = S_ARBIT;
                    w_grant     = '0;
                end else if (w_expire) begin
                    w_nxt_state = S_ARBIT;
                    w_err       = 1'b1;
                    w_grant     = '0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_grant     = '0;
            end
        endcase
        // Grant clear beats a same-cycle request on that port only.
        w_pend = (r_pend | bus.port_req) & ~w_clr;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state  <= S_IDLE;
            r_ref_en <= 1'b0;
            r_op_en  <= 1'b0;
            r_err    <= 1'b0;
            r_grant  <= '0;
            r_pend   <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_ref_en <= w_ref_en;
            r_op_en  <= w_op_en;
            r_err    <= w_err;
            r_grant  <= w_grant;
            r_pend   <= w_pend;
            r_cnt    <= w_cnt;
        end
    end

    assign bus.ref_en      = r_ref_en;
    assign bus.op_en       = r_op_en;
    assign bus.err_timeout = r_err;
    assign bus.grant       = r_grant;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_sdram_arb_rr.sv
// tb_sdram_arb_rr
// Scoreboard bench for sdram_arb_rr (NUM_PORTS=4, TIMEOUT=20). Stimulus
// pushes the expected ref_en/op_en/err_timeout events (kind, grant, cycle)
// into a queue; a monitor pops and compares each event the DUT presents.
module tb_sdram_arb_rr;

    localparam int K_REF = 0;
    localparam int K_OP  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [3:0] grant;
        int         cyc;
    } exp_t;

    logic sclk = 1'b0;
    logic s_rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    sdram_arb_rr_if #(.NUM_PORTS(4)) bus ();

    sdram_arb_rr #(
        .NUM_PORTS (4),
        .TIMEOUT   (20),
        .TO_W      (5)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] kind_flags(input int k);
        case (k)
            K_REF:   return 3'b100;
            K_OP:    return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [4:0] kind_state(input int k);
        case (k)
            K_REF:   return 5'b01000;
            K_OP:    return 5'b10000;
            default: return 5'b00100;
        endcase
    endfunction

    always @(negedge sclk) begin
        if (s_rst_n === 1'b1 && (bus.ref_en || bus.op_en || bus.err_timeout)) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: actual ref/op/err=%b%b%b grant=%b cyc=%0d required no event",
                         bus.ref_en, bus.op_en, bus.err_timeout, bus.grant, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("evt_flags", {bus.ref_en, bus.op_en, bus.err_timeout}, kind_flags(e.kind));
                check("evt_state", bus.state, kind_state(e.kind));
                check("evt_grant", bus.grant, e.grant);
                if (e.cyc >= 0) check("evt_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic push(input int kind, input logic [3:0] grant, input int c);
        exp_t e;
        e.kind  = kind;
        e.grant = grant;
        e.cyc   = c;
        q.push_back(e);
    endtask

    task automatic wait_evt(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge sclk);
            if (bus.ref_en || bus.op_en || bus.err_timeout) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic end_op();
        tick(2);
        bus.flag_op_end = 1'b1;
        tick(1);
        bus.flag_op_end = 1'b0;
    endtask

    task automatic bring_up(input logic [3:0] early_req);
        s_rst_n            = 1'b0;
        bus.key            = 1'b0;
        bus.flag_init_end  = 1'b0;
        bus.ref_req        = 1'b0;
        bus.port_req       = 4'b0000;
        bus.flag_ref_end   = 1'b0;
        bus.flag_op_end    = 1'b0;
        tick(3);
        check("rst_state", bus.state, 5'b00001);
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_pulses", {bus.ref_en, bus.op_en, bus.err_timeout}, 3'b000);
        s_rst_n = 1'b1;
        tick(1);
        check("idle_hold", bus.state, 5'b00001);
        bus.key = 1'b1;
        tick(1);
        bus.key = 1'b0;
        check("init_state", bus.state, 5'b00010);
        bus.port_req = early_req;
        tick(4);
        check("init_wait", bus.state, 5'b00010);
        check("init_outputs", {bus.grant, bus.ref_en, bus.op_en, bus.err_timeout}, 7'd0);
        bus.flag_init_end = 1'b1;
        tick(1);
        bus.flag_init_end = 1'b0;
        check("arbit_state", bus.state, 5'b00100);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq4 [5];
        logic [3:0] seq2 [3];
        int         t;
        int         c;

`ifdef ARB_ROUND_ROBIN_EN
        seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq2 = '{4'b0010, 4'b1000, 4'b0010};
`else
        seq4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        seq2 = '{4'b0010, 4'b0010, 4'b0010};
`endif

        // All ports requesting continuously, op ends 3 cycles after op_en.
        bring_up(4'b0000);
        c = cyc;
        bus.port_req = 4'b1111;
        t = c + 2;
        for (int k = 0; k < 5; k++) begin
            push(K_OP, seq4[k], t);
            wait_evt("wait_op_all", 10);
            t = cyc + 4;
            if (k < 4) end_op();
        end
        tick(1);
        s_rst_n = 1'b0;
        #1;
        check("async_rst_state", bus.state, 5'b00001);
        check("async_rst_grant", bus.grant, 4'b0000);

        // Refresh and port 2 together: refresh first, then port 2.
        bring_up(4'b0000);
        c = cyc;
        push(K_REF, 4'b0000, c + 1);
        push(K_OP, 4'b0100, c + 4);
        bus.ref_req  = 1'b1;
        bus.port_req = 4'b0100;
        wait_evt("wait_ref", 5);
        bus.ref_req  = 1'b0;
        bus.port_req = 4'b0000;
        tick(1);
        bus.flag_ref_end = 1'b1;
        tick(1);
        bus.flag_ref_end = 1'b0;
        wait_evt("wait_op_after_ref", 5);
        end_op();
        tick(2);
        check("op_end_state", bus.state, 5'b00100);
        check("op_end_grant", bus.grant, 4'b0000);

        // Watchdog abort: op never ends.
        c = cyc;
        push(K_OP, 4'b0010, c + 2);
        push(K_ERR, 4'b0000, c + 22);
        bus.port_req = 4'b0010;
        tick(1);
        bus.port_req = 4'b0000;
        wait_evt("wait_op_wd", 5);
        wait_evt("wait_wd_abort", 30);
        tick(1);
        check("err_pulse_width", 32'(bus.err_timeout), 32'd0);
        tick(2);
        check("wd_no_regrant", bus.state, 5'b00100);

        // End flags outside their state are ignored.
        bus.flag_op_end  = 1'b1;
        bus.flag_ref_end = 1'b1;
        tick(1);
        bus.flag_op_end  = 1'b0;
        bus.flag_ref_end = 1'b0;
        tick(1);
        check("stray_flag_state", bus.state, 5'b00100);

        // End flag on the watchdog expiry edge counts as a normal end.
        c = cyc;
        push(K_OP, 4'b1000, c + 2);
        bus.port_req = 4'b1000;
        tick(1);
        bus.port_req = 4'b0000;
        wait_evt("wait_op_tie", 5);
        tick(19);
        bus.flag_op_end = 1'b1;
        tick(1);
        bus.flag_op_end = 1'b0;
        check("tie_state", bus.state, 5'b00100);
        check("tie_err", 32'(bus.err_timeout), 32'd0);
        check("tie_grant", bus.grant, 4'b0000);

        // Requests latched during INIT; ports 1 and 3 held requesting.
        bring_up(4'b1010);
        t = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            push(K_OP, seq2[k], t);
            wait_evt("wait_op_1010", 10);
            t = cyc + 4;
            if (k < 2) end_op();
        end
        tick(1);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("async_rst_state2", bus.state, 5'b00001);
        check("async_rst_grant2", bus.grant, 4'b0000);
        bus.port_req = 4'b0000;

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
